// File: rtl/conv_tile_engine.sv
// Valid-mode (stride 1) convolution of one IN_DIM x IN_DIM tile with a K x K filter,
// computed by a single time-multiplexed MAC and streamed out row-major with saturation.
module conv_tile_engine #(
  parameter int DW     = 2,
  parameter int FW     = 2,
  parameter int K      = 3,
  parameter int IN_DIM = 5,
  parameter int OW     = 2,
  localparam int OUT_DIM = IN_DIM - K + 1,
  localparam int ACCW    = DW + FW + $clog2(K * K),
  localparam int IDXW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_DIM*IN_DIM*DW-1:0] in_tile,
  input  logic [K*K*FW-1:0]          in_filter,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OW-1:0]              out_data,
  output logic [IDXW-1:0]            out_row,
  output logic [IDXW-1:0]            out_col,
  output logic                       out_sat,
  output logic                       out_last,
  output logic                       busy
);

  localparam int TW        = (K > 1) ? $clog2(K) : 1;
  localparam int TILE_SELW = ($clog2(IN_DIM * IN_DIM * DW) > 0) ? $clog2(IN_DIM * IN_DIM * DW) : 1;
  localparam int FILT_SELW = ($clog2(K * K * FW) > 0) ? $clog2(K * K * FW) : 1;

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  state_t                      state, state_next;
  logic [IN_DIM*IN_DIM*DW-1:0] tile_q;
  logic [K*K*FW-1:0]           filter_q;
  logic [ACCW-1:0]             acc, acc_sum;
  logic [TW-1:0]               i, j;
  logic [IDXW-1:0]             r, c;
  logic [TILE_SELW-1:0]        pix_base;
  logic [FILT_SELW-1:0]        wgt_base;
  logic [DW-1:0]               pix;
  logic [FW-1:0]               wgt;
  logic [ACCW+OW-1:0]          acc_ext;
  logic                        sat;
  logic [OW-1:0]               sat_data;
  logic                        taps_done, pos_last, col_wrap;

  always_comb begin
    pix_base = TILE_SELW'(((int'(r) + int'(i)) * IN_DIM + int'(c) + int'(j)) * DW);
    wgt_base = FILT_SELW'((int'(i) * K + int'(j)) * FW);
    pix      = tile_q[pix_base +: DW];
    wgt      = filter_q[wgt_base +: FW];
    acc_sum  = acc + ACCW'(pix) * ACCW'(wgt);
    // Widen before comparing so OW larger than ACCW never saturates.
    acc_ext  = {{OW{1'b0}}, acc_sum};
    sat      = acc_ext > {{ACCW{1'b0}}, {OW{1'b1}}};
    sat_data = sat ? {OW{1'b1}} : acc_ext[OW-1:0];
    taps_done = (i == TW'(K - 1)) && (j == TW'(K - 1));
    col_wrap  = (c == IDXW'(OUT_DIM - 1));
    pos_last  = (r == IDXW'(OUT_DIM - 1)) && col_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        if (taps_done) state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = out_last ? IDLE : MAC;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final MAC cycle registers the result including its own product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q   <= '0;
      filter_q <= '0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      r        <= '0;
      c        <= '0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      out_sat  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tile_q   <= in_tile;
            filter_q <= in_filter;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            r        <= '0;
            c        <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (j == TW'(K - 1)) begin
            j <= '0;
            i <= (i == TW'(K - 1)) ? '0 : i + TW'(1);
          end else begin
            j <= j + TW'(1);
          end
          if (taps_done) begin
            out_data <= sat_data;
            out_sat  <= sat;
            out_row  <= r;
            out_col  <= c;
            out_last <= pos_last;
          end
        end
        EMIT: begin
          if (out_ready && !out_last) begin
            if (col_wrap) begin
              c <= '0;
              r <= r + IDXW'(1);
            end else begin
              c <= c + IDXW'(1);
            end
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_engine.sv
// Directed bench: three 3x3 instances (OW=2/8/6) in lockstep plus one K=IN_DIM instance,
// checking results, tags, timing, backpressure and mid-tile reset.
module tb_conv_tile_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [49:0] in_tile = '0;
  logic [17:0] in_filter = '0;

  logic       ready_v [3];
  logic       valid_v [3];
  logic       sat_v   [3];
  logic       last_v  [3];
  logic       busy_v  [3];
  logic [1:0] row_v   [3];
  logic [1:0] col_v   [3];
  logic [1:0] out_data2;
  logic [7:0] out_data8;
  logic [5:0] out_data6;

  logic        in_valid_k5 = 1'b0;
  logic [49:0] filter_k5 = {25{2'b01}};
  logic        ready_k5, valid_k5, sat_k5, last_k5, busy_k5;
  logic [7:0]  data_k5;
  logic [0:0]  row_k5, col_k5;

  conv_tile_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_v[0]),
    .in_tile(in_tile), .in_filter(in_filter), .out_valid(valid_v[0]), .out_ready(out_ready),
    .out_data(out_data2), .out_row(row_v[0]), .out_col(col_v[0]), .out_sat(sat_v[0]),
    .out_last(last_v[0]), .busy(busy_v[0]));

  conv_tile_engine #(.OW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_v[1]),
    .in_tile(in_tile), .in_filter(in_filter), .out_valid(valid_v[1]), .out_ready(out_ready),
    .out_data(out_data8), .out_row(row_v[1]), .out_col(col_v[1]), .out_sat(sat_v[1]),
    .out_last(last_v[1]), .busy(busy_v[1]));

  conv_tile_engine #(.OW(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_v[2]),
    .in_tile(in_tile), .in_filter(in_filter), .out_valid(valid_v[2]), .out_ready(out_ready),
    .out_data(out_data6), .out_row(row_v[2]), .out_col(col_v[2]), .out_sat(sat_v[2]),
    .out_last(last_v[2]), .busy(busy_v[2]));

  conv_tile_engine #(.K(5), .OW(8)) dut_k5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_k5), .in_ready(ready_k5),
    .in_tile(in_tile), .in_filter(filter_k5), .out_valid(valid_k5), .out_ready(1'b1),
    .out_data(data_k5), .out_row(row_k5), .out_col(col_k5), .out_sat(sat_k5),
    .out_last(last_k5), .busy(busy_k5));

  typedef struct {
    logic [49:0] tile;
    logic [17:0] filter;
    int          raw [9];
  } vec_t;

  vec_t vecs [4];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [49:0] make_tile(input int mode);
    logic [49:0] t;
    int v;
    t = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        case (mode)
          0:       v = 1;
          1:       v = (r + c) % 4;
          2:       v = 3;
          default: v = c % 4;
        endcase
        t[(r*5+c)*2 +: 2] = 2'(v);
      end
    return t;
  endfunction

  function automatic logic [17:0] make_filter(input int mode);
    logic [17:0] f;
    int v;
    f = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        case (mode)
          0:       v = 1;
          1:       v = (i == 1 && j == 1) ? 1 : 0;
          2:       v = 3;
          default: v = (i == 0 && j == 0) ? 2 : 0;
        endcase
        f[(i*3+j)*2 +: 2] = 2'(v);
      end
    return f;
  endfunction

  // Waits for in_ready, performs one accept, then scrambles the inputs.
  task automatic apply_stimulus(input logic [49:0] tile, input logic [17:0] filter, output int accept_cycle);
    int n;
    n = 0;
    while (!ready_v[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 0, 1);
    in_tile   = tile;
    in_filter = filter;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    accept_cycle = cycle;
    in_valid  = 1'b0;
    in_tile   = ~tile;
    in_filter = ~filter;
    @(negedge clk);
  endtask

  task automatic check_output(input int vidx, input int k);
    int ow, maxv, raw, exp_data, exp_sat;
    logic [31:0] act;
    for (int inst = 0; inst < 3; inst++) begin
      ow       = (inst == 0) ? 2 : (inst == 1) ? 8 : 6;
      maxv     = (1 << ow) - 1;
      raw      = vecs[vidx].raw[k];
      exp_sat  = (raw > maxv) ? 1 : 0;
      exp_data = exp_sat ? maxv : raw;
      act = (inst == 0) ? 32'(out_data2) : (inst == 1) ? 32'(out_data8) : 32'(out_data6);
      check($sformatf("v%0d_ow%0d_k%0d_valid", vidx, ow, k), 32'(valid_v[inst]), 1);
      check($sformatf("v%0d_ow%0d_k%0d_data", vidx, ow, k), act, exp_data);
      check($sformatf("v%0d_ow%0d_k%0d_sat", vidx, ow, k), 32'(sat_v[inst]), exp_sat);
      check($sformatf("v%0d_ow%0d_k%0d_row", vidx, ow, k), 32'(row_v[inst]), k / 3);
      check($sformatf("v%0d_ow%0d_k%0d_col", vidx, ow, k), 32'(col_v[inst]), k % 3);
      check($sformatf("v%0d_ow%0d_k%0d_last", vidx, ow, k), 32'(last_v[inst]), (k == 8) ? 1 : 0);
    end
  endtask

  // Collects outputs first..first+count-1 with out_ready high.
  task automatic collect(input int vidx, input int first, input int count, input int accept_cycle, input bit timing);
    int n;
    for (int k = first; k < first + count; k++) begin
      n = 0;
      while (!valid_v[0] && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        check("valid_timeout", 0, 1);
        return;
      end
      if (timing && k == 0) check("first_valid_latency", 32'(cycle - accept_cycle), 9);
      check_output(vidx, k);
      @(negedge clk);
    end
    if (timing && first + count == 9) begin
      check("tile_duration", 32'(cycle - accept_cycle), 90);
      check("idle_in_ready", 32'(ready_v[0]), 1);
      check("idle_busy", 32'(busy_v[0]), 0);
      check("idle_out_valid", 32'(valid_v[0]), 0);
    end
  endtask

  initial begin
    int a, n;

    vecs[0].tile = make_tile(0); vecs[0].filter = make_filter(0); vecs[0].raw = '{default: 9};
    vecs[1].tile = make_tile(1); vecs[1].filter = make_filter(1); vecs[1].raw = '{2, 3, 0, 3, 0, 1, 0, 1, 2};
    vecs[2].tile = make_tile(2); vecs[2].filter = make_filter(2); vecs[2].raw = '{default: 81};
    vecs[3].tile = make_tile(3); vecs[3].filter = make_filter(3); vecs[3].raw = '{0, 2, 4, 0, 2, 4, 0, 2, 4};

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(valid_v[0]), 0);
    check("rst_busy", 32'(busy_v[0]), 0);
    check("rst_in_ready", 32'(ready_v[0]), 1);
    check("rst_out_data", 32'(out_data2), 0);
    check("rst_out_row", 32'(row_v[0]), 0);
    check("rst_out_col", 32'(col_v[0]), 0);
    check("rst_out_sat", 32'(sat_v[0]), 0);
    check("rst_out_last", 32'(last_v[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].tile, vecs[v].filter, a);
      collect(v, 0, 9, a, 1'b1);
    end

    // Single-output boundary: K equals the tile side.
    in_tile = make_tile(0);
    in_valid_k5 = 1'b1;
    @(posedge clk);
    #1;
    a = cycle;
    in_valid_k5 = 1'b0;
    @(negedge clk);
    n = 0;
    while (!valid_k5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("k5_latency", 32'(cycle - a), 25);
    check("k5_data", 32'(data_k5), 25);
    check("k5_sat", 32'(sat_k5), 0);
    check("k5_row", 32'(row_k5), 0);
    check("k5_col", 32'(col_k5), 0);
    check("k5_last", 32'(last_k5), 1);
    @(negedge clk);
    check("k5_valid_drop", 32'(valid_k5), 0);
    check("k5_in_ready", 32'(ready_k5), 1);

    // Backpressure on output (0,1) with ignored in_valid pulses.
    apply_stimulus(vecs[0].tile, vecs[0].filter, a);
    collect(0, 0, 1, a, 1'b0);
    n = 0;
    while (!valid_v[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_valid", 32'(valid_v[0]), 1);
    out_ready = 1'b0;
    in_tile   = '0;
    in_filter = '0;
    for (int p = 0; p < 5; p++) begin
      in_valid = (p % 2 == 0);
      @(negedge clk);
      check($sformatf("bp%0d_valid", p), 32'(valid_v[0]), 1);
      check($sformatf("bp%0d_data", p), 32'(out_data2), 3);
      check($sformatf("bp%0d_data8", p), 32'(out_data8), 9);
      check($sformatf("bp%0d_row", p), 32'(row_v[0]), 0);
      check($sformatf("bp%0d_col", p), 32'(col_v[0]), 1);
      check($sformatf("bp%0d_in_ready", p), 32'(ready_v[0]), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output(0, 1);
    @(negedge clk);
    collect(0, 2, 7, a, 1'b0);
    check("bp_end_in_ready", 32'(ready_v[0]), 1);
    check("bp_end_out_valid", 32'(valid_v[0]), 0);

    // Reset during the MAC phase of output (1,1), then a fresh tile.
    apply_stimulus(vecs[1].tile, vecs[1].filter, a);
    collect(1, 0, 4, a, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy_v[0]), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(valid_v[0]), 0);
    check("midrst_busy", 32'(busy_v[0]), 0);
    check("midrst_in_ready", 32'(ready_v[0]), 1);
    check("midrst_out_data8", 32'(out_data8), 0);
    check("midrst_out_last", 32'(last_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(vecs[3].tile, vecs[3].filter, a);
    collect(3, 0, 9, a, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
